// File: rtl/uart_tx_sequencer.sv
// UART transmit frame sequencer: start bit, LSB-first data, optional even parity, stop time.
// Define UART_TX_PARITY_EN to add the parity bit after the data bits.
module uart_tx_sequencer #(
  parameter int DATA_BITS    = 8,
  parameter int OVERSAMPLING = 16,
  parameter int STOP_TICKS   = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_tick,
  input  logic [DATA_BITS-1:0] i_data,
  input  logic                 i_valid,
  output logic                 o_ready,
  output logic                 o_tx,
  output logic                 o_busy,
  output logic                 o_done
);
  localparam int TMAX = (OVERSAMPLING > STOP_TICKS) ? OVERSAMPLING : STOP_TICKS;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int BW   = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [TW-1:0] BIT_LAST  = TW'(OVERSAMPLING - 1);
  localparam logic [TW-1:0] STOP_LAST = TW'(STOP_TICKS - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t               state, state_nx;
  logic [TW-1:0]        tick_cnt, tick_nx;
  logic [BW-1:0]        bit_cnt, bit_nx;
  logic [DATA_BITS-1:0] shreg, shreg_nx;
  logic                 tx_nx, done_nx, accept, bit_end;
`ifdef UART_TX_PARITY_EN
  logic                 par;
`endif

  assign o_ready = (state == IDLE);
  assign o_busy  = (state != IDLE);
  assign accept  = i_valid & o_ready;
  assign bit_end = i_tick && (tick_cnt == BIT_LAST);

  always_comb begin
    state_nx = state;
    tick_nx  = tick_cnt;
    bit_nx   = bit_cnt;
    shreg_nx = shreg;
    done_nx  = 1'b0;
    if (state != IDLE && i_tick) tick_nx = tick_cnt + 1'b1;
    case (state)
      IDLE: if (accept) begin
        state_nx = START;
        shreg_nx = i_data;
        tick_nx  = '0;
        bit_nx   = '0;
      end
      START: if (bit_end) begin
        state_nx = DATA;
        tick_nx  = '0;
      end
      DATA: if (bit_end) begin
        tick_nx  = '0;
        shreg_nx = shreg >> 1;
        if (bit_cnt == DATA_LAST) begin
          bit_nx = '0;
`ifdef UART_TX_PARITY_EN
          state_nx = PARITY;
`else
          state_nx = STOP;
`endif
        end else begin
          bit_nx = bit_cnt + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (bit_end) begin
        state_nx = STOP;
        tick_nx  = '0;
      end
`endif
      STOP: if (i_tick && tick_cnt == STOP_LAST) begin
        state_nx = IDLE;
        tick_nx  = '0;
        done_nx  = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
    // o_tx is a flop, so it is loaded with the level of the state being entered
    case (state_nx)
      START:   tx_nx = 1'b0;
      DATA:    tx_nx = shreg_nx[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_nx = par;
`endif
      default: tx_nx = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      o_tx     <= 1'b1;
      o_done   <= 1'b0;
    end else begin
      state    <= state_nx;
      tick_cnt <= tick_nx;
      bit_cnt  <= bit_nx;
      shreg    <= shreg_nx;
      o_tx     <= tx_nx;
      o_done   <= done_nx;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)     par <= 1'b0;
    else if (accept) par <= ^i_data;
  end
`endif
endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Bench for uart_tx_sequencer: vector table of frames, line decoder with expected-byte queue,
// plus hand sequences for busy isolation, back-to-back frames, slow ticks and mid-frame reset.
module tb_uart_tx_sequencer;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int DB = 8, OS = 16, ST = 16;
  localparam int FT = (1 + DB + P) * OS + ST;

  logic       clk = 1'b0, rst = 1'b0, tick = 1'b0, valid = 1'b0;
  logic [7:0] data = 8'h00;
  logic       ready, tx, busy, done;

  always #5 clk = ~clk;

  uart_tx_sequencer dut (
    .i_clk(clk), .i_reset(rst), .i_tick(tick), .i_data(data), .i_valid(valid),
    .o_ready(ready), .o_tx(tx), .o_busy(busy), .o_done(done)
  );

  int checks = 0, failures = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // tick source: one pulse every tick_per cycles, changed on the falling edge
  int tick_per = 4, tph = 0;
  initial forever begin
    @(negedge clk);
    if (tick_per <= 1) tick = (tick_per == 1);
    else begin
      tph  = (tph + 1 >= tick_per) ? 0 : tph + 1;
      tick = (tph == tick_per - 1);
    end
  end

  int done_cnt = 0;
  initial forever begin
    @(posedge clk); #1;
    if (done) done_cnt++;
  end

  typedef struct {logic [7:0] d; logic p;} exp_t;
  exp_t sbq[$];
  int   n_push = 0, mon_frames = 0;
  bit   mon_en = 1'b1;

  // line decoder: samples each bit mid-period, checks against the queued byte
  initial begin : mon
    logic       prev, st0, gp, sp;
    logic [7:0] got;
    int         bw;
    exp_t       e;
    prev = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (mon_en && prev && !tx && !rst) begin
        bw = OS * tick_per;
        gp = 1'b0;
        repeat (bw / 2) @(posedge clk);
        #1 st0 = tx;
        for (int i = 0; i < DB; i++) begin
          repeat (bw) @(posedge clk);
          #1 got[i] = tx;
        end
`ifdef UART_TX_PARITY_EN
        repeat (bw) @(posedge clk);
        #1 gp = tx;
`endif
        repeat (bw) @(posedge clk);
        #1 sp = tx;
        if (sbq.size() == 0) chk("sb_underflow", sbq.size(), 1);
        else begin
          e = sbq.pop_front();
          chk("line_start_bit", st0, 1'b0);
          chk("line_data", got, e.d);
`ifdef UART_TX_PARITY_EN
          chk("line_parity", gp, e.p);
`endif
          chk("line_stop_bit", sp, 1'b1);
          mon_frames++;
        end
      end
      prev = tx;
    end
  end

  task automatic push(input logic [7:0] d, input logic p);
    exp_t e;
    e.d = d; e.p = p;
    sbq.push_back(e);
    n_push++;
  endtask

  task automatic wait_accept(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      if (ready) begin ok = 1'b1; break; end
    end
    if (!ok) chk("accept_timeout", 0, 1);
  endtask

  // counts cycles and sampled ticks after accept until o_done is seen
  task automatic wait_done(output int cyc, output int nt, output int rdy, output bit last_tk);
    cyc = 0; nt = 0; rdy = 0; last_tk = 1'b0;
    for (int i = 0; i < 40000; i++) begin
      @(posedge clk);
      last_tk = tick;
      if (tick) nt++;
      #1 cyc++;
      if (done) return;
      if (ready) rdy++;
    end
    chk("done_timeout", 0, 1);
  endtask

  typedef struct {logic [7:0] d; int per; logic par;} vec_t;
  vec_t tbl[6];

  initial begin
    bit   ok, ltk, acc;
    int   cyc, nt, rdy, d0, lows;
    tbl[0] = '{8'h55, 4, 1'b0};
    tbl[1] = '{8'h00, 1, 1'b0};
    tbl[2] = '{8'hFF, 2, 1'b0};
    tbl[3] = '{8'h07, 4, 1'b1};
    tbl[4] = '{8'h03, 4, 1'b0};
    tbl[5] = '{8'h80, 3, 1'b1};

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_tx", tx, 1'b1);
    chk("reset_ready", ready, 1'b1);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    @(negedge clk) rst = 1'b0;
    repeat (5) @(posedge clk);

    foreach (tbl[k]) begin
      tick_per = tbl[k].per;
      @(negedge clk);
      data = tbl[k].d; valid = 1'b1;
      wait_accept(ok);
      push(tbl[k].d, tbl[k].par);
      #1;
      chk("accept_tx_low", tx, 1'b0);
      chk("accept_busy", busy, 1'b1);
      @(negedge clk) valid = 1'b0;
      wait_done(cyc, nt, rdy, ltk);
      chk("frame_ticks", nt, FT);
      chk("done_after_last_tick", ltk, 1'b1);
      chk("ready_low_in_frame", rdy, 0);
      chk("done_ready", ready, 1'b1);
      chk("done_busy", busy, 1'b0);
      @(posedge clk); #1;
      chk("done_one_cycle", done, 1'b0);
      repeat (10) @(posedge clk);
    end

    // inputs changing while busy must not disturb the frame
    tick_per = 2;
    @(negedge clk);
    data = 8'h3A; valid = 1'b1;
    wait_accept(ok);
    push(8'h3A, 1'b0);
    @(negedge clk) valid = 1'b0;
    fork
      wait_done(cyc, nt, rdy, ltk);
      begin
        repeat (60) @(negedge clk);
        data = 8'hFF;
        repeat (40) begin @(negedge clk); valid = ~valid; end
        valid = 1'b0;
      end
    join
    chk("busy_ignore_ticks", nt, FT);
    chk("busy_ignore_ready", rdy, 0);
    repeat (10) @(posedge clk);

    // back-to-back with valid held high
    tick_per = 1;
    d0 = done_cnt;
    @(negedge clk);
    data = 8'hA5; valid = 1'b1;
    wait_accept(ok);
    push(8'hA5, 1'b0);
    @(negedge clk) data = 8'h3C;
    wait_done(cyc, nt, rdy, ltk);
    chk("b2b_first_ticks", nt, FT);
    @(posedge clk);
    acc = ready;
    chk("b2b_accept_on_done", acc, 1'b1);
    push(8'h3C, 1'b0);
    #1 chk("b2b_second_start", tx, 1'b0);
    @(negedge clk) valid = 1'b0;
    wait_done(cyc, nt, rdy, ltk);
    chk("b2b_second_ticks", nt, FT);
    repeat (20) @(posedge clk);
    chk("b2b_done_pulses", done_cnt - d0, 2);

    // slow ticks: start-bit length, then reset in the middle of the frame
    mon_en = 1'b0;
    tick_per = 163;
    @(negedge clk);
    data = 8'h01; valid = 1'b1;
    wait_accept(ok);
    @(negedge clk) valid = 1'b0;
    nt = 0; cyc = 0;
    for (int i = 0; i < 5000; i++) begin
      @(posedge clk);
      if (tick) nt++;
      #1 cyc++;
      if (tx) break;
    end
    chk("start_bit_ticks", nt, OS);
    chk("start_bit_cycles_in_range", (cyc > 15 * 163 && cyc <= 16 * 163), 1'b1);
    repeat (1300 + 16 * 163) @(posedge clk);
    #1 chk("mid_bit1_tx", tx, 1'b0);
    @(negedge clk) rst = 1'b1;
    #1;
    chk("abort_tx", tx, 1'b1);
    chk("abort_ready", ready, 1'b1);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    @(negedge clk) rst = 1'b0;
    tick_per = 1;
    d0 = done_cnt; lows = 0;
    repeat (300) begin
      @(posedge clk); #1;
      if (!tx || busy) lows++;
    end
    chk("no_resume_after_reset", lows, 0);
    chk("no_done_after_abort", done_cnt - d0, 0);
    mon_en = 1'b1;

    chk("monitor_frames", mon_frames, n_push);
    chk("scoreboard_drained", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
